// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM breathing sequencer.
//   state_e     : FSM state encodings (also exported on the debug 'state' port)
//   MIN_PERIOD  : smallest period the sequencer will program into perip_PWM
//   CNT_W_DEF   : default datapath width for period/duty/counter
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } state_e;

    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned CNT_W_DEF  = 32;

endpackage

// File: rtl/pwm_period_tick.sv
// Period counter that mirrors perip_PWM's own counter.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   clear_i      : hold the counter at 0 for the next cycle (idle / start)
//   freq_nxt_i   : period value that will be in effect next cycle
//   period_end_o : registered pulse, high on the last cycle of each period
module pwm_period_tick
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] freq_nxt_i,
    output logic             period_end_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pe_q, pe_d;

    // The pulse is registered, so it is predicted from next-cycle count and
    // next-cycle period; this keeps it aligned with cnt == period-1 even on
    // the cycle right after a period reload.
    always_comb begin
        cnt_d = (clear_i || pe_q) ? '0 : cnt_q + CNT_W'(1);
        pe_d  = !clear_i && (cnt_d == freq_nxt_i - CNT_W'(1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            pe_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pe_q  <= pe_d;
        end
    end

    assign period_end_o = pe_q;

endmodule

// File: rtl/pwm_breath_ctrl.sv
// Breathing-effect sequencer for one perip_PWM channel.
//   CLK, RST_n   : clock, asynchronous active-low reset
//   en           : 1 = run the breathing sequence, 0 = stop with duty 0
//   period_set   : requested PWM period (clamped to at least MIN_PERIOD)
//   step_set     : duty change per period (0 treated as 1)
//   hold_set     : periods to dwell at full and at zero duty
//   FREQ_Cnt_Set : period value to perip_PWM
//   Chn_duty_Set : duty value to perip_PWM
//   period_end   : pulse on the last cycle of each period
//   state        : FSM state code (debug)
//   busy         : high whenever state != IDLE
module pwm_breath_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned HOLD_W = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  period_set,
    input  logic [CNT_W-1:0]  step_set,
    input  logic [HOLD_W-1:0] hold_set,
    output logic [CNT_W-1:0]  FREQ_Cnt_Set,
    output logic [CNT_W-1:0]  Chn_duty_Set,
    output logic              period_end,
    output logic [2:0]        state,
    output logic              busy
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  freq_q, freq_d;
    logic [CNT_W-1:0]  duty_q, duty_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q;

    logic [CNT_W-1:0]  eff_period, eff_step;
    logic [CNT_W:0]    sum;
    logic [CNT_W-1:0]  up_duty, dn_duty, raw_duty;
    logic [HOLD_W:0]   hold_inc;
    logic              hold_done;
    logic              pe_w;
    logic              tick_clear;

    pwm_period_tick #(
        .CNT_W(CNT_W)
    ) u_tick (
        .clk_i        (CLK),
        .rst_ni       (RST_n),
        .clear_i      (tick_clear),
        .freq_nxt_i   (freq_d),
        .period_end_o (pe_w)
    );

    // Counter restarts from 0 both while idle and on the start edge.
    assign tick_clear = (state_d == IDLE) || (state_q == IDLE);

    always_comb begin
        eff_period = (period_set < MIN_P) ? MIN_P : period_set;
        eff_step   = (step_set == '0) ? ONE : step_set;
        // One extra bit so a huge step saturates instead of wrapping.
        sum        = {1'b0, duty_q} + {1'b0, eff_step};
        up_duty    = (sum > {1'b0, freq_q}) ? freq_q : sum[CNT_W-1:0];
        dn_duty    = (duty_q > eff_step) ? duty_q - eff_step : '0;
        hold_inc   = {1'b0, hold_q} + (HOLD_W+1)'(1);
        hold_done  = (hold_inc >= {1'b0, hold_set});

        raw_duty = duty_q;
        state_d  = state_q;
        freq_d   = freq_q;
        duty_d   = duty_q;
        hold_d   = hold_q;

        if (!en) begin
            state_d = IDLE;
            duty_d  = '0;
            hold_d  = '0;
        end else if (state_q == IDLE) begin
            state_d = RAMP_UP;
            freq_d  = eff_period;
            duty_d  = '0;
            hold_d  = '0;
        end else if (pe_w) begin
            case (state_q)
                RAMP_UP: raw_duty = up_duty;
                RAMP_DN: raw_duty = dn_duty;
                default: raw_duty = duty_q;
            endcase
            // New period and duty clamp land together on the boundary.
            freq_d = eff_period;
            duty_d = (raw_duty > eff_period) ? eff_period : raw_duty;
            case (state_q)
                RAMP_UP: if (duty_d == eff_period) begin
                    state_d = HOLD_HI;
                    hold_d  = '0;
                end
                HOLD_HI: if (hold_done) begin
                    state_d = RAMP_DN;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_inc[HOLD_W-1:0];
                end
                RAMP_DN: if (duty_d == '0) begin
                    state_d = HOLD_LO;
                    hold_d  = '0;
                end
                HOLD_LO: if (hold_done) begin
                    state_d = RAMP_UP;
                    hold_d  = '0;
                end else begin
                    hold_d  = hold_inc[HOLD_W-1:0];
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= IDLE;
            freq_q  <= '0;
            duty_q  <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            duty_q  <= duty_d;
            hold_q  <= hold_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign FREQ_Cnt_Set = freq_q;
    assign Chn_duty_Set = duty_q;
    assign period_end   = pe_w;
    assign state        = state_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
module tb_pwm_breath_ctrl;

    logic        CLK = 1'b0;
    logic        RST_n;
    logic        en;
    logic [31:0] period_set, step_set;
    logic [15:0] hold_set;
    logic [31:0] FREQ_Cnt_Set, Chn_duty_Set;
    logic        period_end;
    logic [2:0]  state;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_pe = 0;

    pwm_breath_ctrl dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .en           (en),
        .period_set   (period_set),
        .step_set     (step_set),
        .hold_set     (hold_set),
        .FREQ_Cnt_Set (FREQ_Cnt_Set),
        .Chn_duty_Set (Chn_duty_Set),
        .period_end   (period_end),
        .state        (state),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase, period, duty, position within period, hold count.
    typedef struct packed {
        int unsigned      st;
        longint unsigned  freq;
        longint unsigned  duty;
        longint unsigned  pos;
        longint unsigned  hold;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_next(mstate_t s, logic run, longint unsigned ps,
                                           longint unsigned ss, longint unsigned hs);
        mstate_t n = s;
        longint unsigned p   = (ps < 2) ? 2 : ps;
        longint unsigned stp = (ss == 0) ? 1 : ss;
        longint unsigned d;
        if (!run) begin
            n.st = 0; n.duty = 0; n.pos = 0; n.hold = 0;
            return n;
        end
        if (s.st == 0) begin
            n.st = 1; n.freq = p; n.duty = 0; n.pos = 0; n.hold = 0;
            return n;
        end
        if (s.pos != s.freq - 1) begin
            n.pos = s.pos + 1;
            return n;
        end
        n.pos  = 0;
        n.freq = p;
        case (s.st)
            1:       d = (s.duty + stp > s.freq) ? s.freq : s.duty + stp;
            3:       d = (s.duty > stp) ? s.duty - stp : 0;
            default: d = s.duty;
        endcase
        if (d > p) d = p;
        n.duty = d;
        case (s.st)
            1: if (d == p) begin n.st = 2; n.hold = 0; end
            2: if (s.hold + 1 >= hs) begin n.st = 3; n.hold = 0; end else n.hold = s.hold + 1;
            3: if (d == 0) begin n.st = 4; n.hold = 0; end
            4: if (s.hold + 1 >= hs) begin n.st = 1; n.hold = 0; end else n.hold = s.hold + 1;
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) m <= '0;
        else        m <= model_next(m, en, period_set, step_set, hold_set);
    end

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        chk("freq",  FREQ_Cnt_Set, m.freq);
        chk("duty",  Chn_duty_Set, m.duty);
        chk("state", state, m.st);
        chk("busy",  busy, (m.st != 0) ? 1 : 0);
        chk("pend",  period_end, (m.st != 0 && m.pos == m.freq - 1) ? 1 : 0);
    end

    task automatic wait_pe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (period_end) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    // Wait for the next boundary, then check the values it produced.
    task automatic expect_boundary(input string name, input longint unsigned d,
                                   input int st, input int gap);
        bit ok;
        wait_pe(ok);
        if (!ok) begin
            chk({name, "_timeout"}, 0, 1);
            return;
        end
        if (gap != 0) chk({name, "_gap"}, cyc - last_pe, gap);
        last_pe = cyc;
        @(negedge CLK);
        chk({name, "_duty"}, Chn_duty_Set, d);
        chk({name, "_state"}, state, st);
        chk({name, "_model"}, m.duty, d);
    endtask

    task automatic restart(input logic [31:0] p, input logic [31:0] s, input logic [15:0] h);
        @(negedge CLK);
        en = 1'b0;
        @(negedge CLK);
        period_set = p; step_set = s; hold_set = h; en = 1'b1;
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rnd_step();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFF - 32'($urandom_range(0, 5));
        return 32'($urandom_range(0, 12));
    endfunction

    initial begin
        RST_n = 1'b0; en = 1'b0;
        period_set = '0; step_set = '0; hold_set = '0;
        repeat (3) @(negedge CLK);
        chk("rst_state", state, 0);
        chk("rst_duty", Chn_duty_Set, 0);
        chk("rst_freq", FREQ_Cnt_Set, 0);
        chk("rst_busy", busy, 0);
        RST_n = 1'b1;

        // Reset asserted mid-run takes effect without a clock edge.
        period_set = 10; step_set = 4; hold_set = 2; en = 1'b1;
        repeat (15) @(negedge CLK);
        #2 RST_n = 1'b0;
        #1;
        chk("async_state", state, 0);
        chk("async_duty", Chn_duty_Set, 0);
        chk("async_freq", FREQ_Cnt_Set, 0);
        chk("async_pend", period_end, 0);
        chk("async_busy", busy, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        @(negedge CLK);
        chk("rel_state", state, 1);
        chk("rel_freq", FREQ_Cnt_Set, 10);
        chk("rel_duty", Chn_duty_Set, 0);

        // Ramp / hold / ramp-down / hold cycle.
        expect_boundary("sat1", 4, 1, 0);
        expect_boundary("sat2", 8, 1, 10);
        expect_boundary("sat3", 10, 2, 10);
        expect_boundary("sat4", 10, 2, 10);
        expect_boundary("sat5", 10, 3, 10);
        expect_boundary("sat6", 6, 3, 10);
        expect_boundary("sat7", 2, 3, 10);
        expect_boundary("sat8", 0, 4, 10);
        expect_boundary("sat9", 0, 4, 10);
        expect_boundary("sat10", 0, 1, 10);
        expect_boundary("sat11", 4, 1, 10);

        // Degenerate inputs are clamped.
        restart(0, 0, 0);
        chk("deg_freq", FREQ_Cnt_Set, 2);
        expect_boundary("deg1", 1, 1, 0);
        expect_boundary("deg2", 2, 2, 2);
        expect_boundary("deg3", 2, 3, 2);
        expect_boundary("deg4", 1, 3, 2);
        expect_boundary("deg5", 0, 4, 2);

        // Period shrink mid-ramp clamps duty and saturates.
        restart(100, 30, 5);
        expect_boundary("shr1", 30, 1, 0);
        expect_boundary("shr2", 60, 1, 100);
        expect_boundary("shr3", 90, 1, 100);
        period_set = 50;
        expect_boundary("shr4", 50, 2, 100);
        chk("shr_freq", FREQ_Cnt_Set, 50);

        // Abort during ramp-down, then restart from zero.
        restart(10, 4, 0);
        expect_boundary("ab1", 4, 1, 0);
        expect_boundary("ab2", 8, 1, 10);
        expect_boundary("ab3", 10, 2, 10);
        expect_boundary("ab4", 10, 3, 10);
        expect_boundary("ab5", 6, 3, 10);
        en = 1'b0;
        @(negedge CLK);
        chk("ab_state", state, 0);
        chk("ab_duty", Chn_duty_Set, 0);
        chk("ab_busy", busy, 0);
        chk("ab_freq", FREQ_Cnt_Set, 10);
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            chk("ab_nopend", period_end, 0);
        end
        en = 1'b1;
        @(negedge CLK);
        chk("ab_re_state", state, 1);
        chk("ab_re_duty", Chn_duty_Set, 0);
        expect_boundary("ab6", 4, 1, 0);

        // Full-range step saturates without overflow.
        restart(1000, 32'hFFFF_FFFF, 0);
        expect_boundary("wide1", 1000, 2, 0);
        expect_boundary("wide2", 1000, 3, 1000);
        expect_boundary("wide3", 0, 4, 1000);

        // Randomized episodes, checked every cycle against the model.
        for (int ep = 0; ep < 30; ep++) begin
            restart(32'($urandom_range(0, 16)), rnd_step(), 16'($urandom_range(0, 3)));
            repeat ($urandom_range(40, 200)) begin
                @(negedge CLK);
                if ($urandom_range(0, 24) == 0) period_set = 32'($urandom_range(0, 16));
                if ($urandom_range(0, 24) == 0) step_set = rnd_step();
                if ($urandom_range(0, 24) == 0) hold_set = 16'($urandom_range(0, 3));
                en = ($urandom_range(0, 49) != 0);
            end
        end

        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_breath_ctrl.md
Name: pwm_breath_ctrl

Overview:
- Sequencer that configures a single perip_PWM channel for a "breathing" brightness effect on LED or buzzer lines.
- Drives FREQ_Cnt_Set and Chn_duty_Set, stepping duty up and down on PWM period boundaries.
- Runs a period counter that mirrors the PWM's own, so duty and period updates land only at period wrap; no glitched pulses.
- Sits between top-level template logic and perip_PWM, replacing constant configuration values.

Parameters:
- CNT_W, 32, width of period/duty/counter datapath.
- HOLD_W, 16, width of hold-count input.

Ports:
- CLK  input  1  system clock.
- RST_n  input  1  asynchronous active-low reset.
- en  input  1  level; 1 = run breathing sequence, 0 = stop and force duty 0.
- period_set  input  CNT_W  requested PWM period in CLK cycles.
- step_set  input  CNT_W  duty increment/decrement per period.
- hold_set  input  HOLD_W  periods to dwell at full and at zero duty.
- FREQ_Cnt_Set  output  CNT_W  period value to perip_PWM.
- Chn_duty_Set  output  CNT_W  duty value to perip_PWM.
- period_end  output  1  one-cycle pulse on the last cycle of each period.
- state  output  3  current FSM state code, for debug.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, RST_n=0): cnt=0, FREQ_Cnt_Set=0, Chn_duty_Set=0, period_end=0, state=IDLE, busy=0, hold counter=0.
- Clamping at sample time:
  - eff_period = max(period_set, 2).
  - eff_step = (step_set==0) ? 1 : step_set.
- period_set, step_set and hold_set are sampled only when entering RAMP_UP from IDLE and at each period boundary.
- Period counter (non-IDLE states only):
  - cnt increments each cycle; at cnt == FREQ_Cnt_Set-1 it wraps to 0 and period_end=1 for that cycle.
  - Boundary = the cycle period_end is high. All duty, period and state updates happen on the clock edge ending that cycle.
- FSM states: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4.
  - IDLE, en=1 -> RAMP_UP next cycle.
    - FREQ_Cnt_Set=eff_period, Chn_duty_Set=0, cnt=0.
    - First boundary occurs eff_period cycles later.
  - RAMP_UP, at boundary: duty = min(duty+eff_step, FREQ_Cnt_Set).
    - Saturation compare uses CNT_W+1 bits; no wrap.
    - If the result equals FREQ_Cnt_Set -> HOLD_HI, hold counter=0.
  - HOLD_HI, at boundary: hold counter++. When it reaches hold_set -> RAMP_DN.
    - hold_set==0 -> RAMP_DN at the first boundary.
  - RAMP_DN, at boundary: duty = (duty > eff_step) ? duty-eff_step : 0.
    - If the result == 0 -> HOLD_LO, hold counter=0.
  - HOLD_LO: same as HOLD_HI, then -> RAMP_UP.
- Period change mid-run: the new eff_period loads into FREQ_Cnt_Set at the next boundary.
  - Chn_duty_Set is clamped to the new period in the same update.
  - If the clamp makes duty == new period while in RAMP_UP, go to HOLD_HI.
- en deasserted in any non-IDLE state: next edge -> IDLE with Chn_duty_Set=0, cnt=0, period_end=0. FREQ_Cnt_Set holds its value. No wait for boundary.
- en held 1: the sequence loops indefinitely. Re-assertion after IDLE restarts from duty 0.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (pwm_pkg) holds:
  - state encodings IDLE..HOLD_LO;
  - constant MIN_PERIOD=2;
  - default CNT_W=32.
- One natural sub-module: pwm_period_tick, which holds the counter, wrap compare and period_end pulse.
- The FSM and duty arithmetic stay in the top module.
- Top-level integration: instantiate beside perip_PWM, wire FREQ_Cnt_Set/Chn_duty_Set through, and replace the constants 10000/1000.

Test Plan:
- Reset: hold RST_n=0 mid-run with en=1 -> all outputs 0 and state=IDLE asynchronously; on release with en=1, RAMP_UP one cycle later.
- Ramp saturate: period_set=10, step_set=4, hold_set=2, en=1.
  - Duty sequence at boundaries: 4, 8, 10 (HOLD_HI), 10, 10, then RAMP_DN 6, 2, 0 (HOLD_LO), 0, 0, then 4.
  - period_end pulses exactly every 10 cycles.
- Degenerate inputs: period_set=0, step_set=0, hold_set=0 -> FREQ_Cnt_Set=2, duty 1, 2 (HOLD_HI), immediate RAMP_DN at next boundary, 1, 0.
- Mid-run period shrink: period 100, step 30, duty=90, then set period_set=50 -> at next boundary FREQ_Cnt_Set=50, Chn_duty_Set=50, state=HOLD_HI.
- Abort: drop en during RAMP_DN at duty 6 -> next cycle state=IDLE, Chn_duty_Set=0, busy=0, no further period_end; re-raise en -> restart at duty 0.
- Wide step: period 1000, step 2^CNT_W-1 -> duty saturates to 1000 in one boundary with no overflow, then reaches 0 in one RAMP_DN step.
